// File: rtl/micro_uaz_defs.sv
// rtl/micro_uaz_defs.sv - shared definitions for the bus access sequencer
// Purpose: sequencer state encodings, default bus widths and R/W encodings.
// Ports: none (package).
package micro_uaz_defs;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } bas_state_t;

endpackage

// File: rtl/bus_access_sequencer_if.sv
// rtl/bus_access_sequencer_if.sv - 4-phase req/ack memory bus interface
// Purpose: groups the memory handshake and the address/data buses.
// Ports (named from the sequencer side):
//   o_Mem_Req    request, asserted by the sequencer
//   o_Mem_We     write enable, stable while o_Mem_Req is high
//   o_Mem_Addr   address, stable while o_Mem_Req is high
//   o_Mem_Wdata  write data, stable while o_Mem_Req is high
//   i_Mem_Ack    acknowledge from memory
//   i_Mem_Rdata  read data, valid while i_Mem_Ack is high
// Modports: master = sequencer, slave = memory.
interface bus_access_sequencer_if
    import micro_uaz_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              o_Mem_Req;
    logic              o_Mem_We;
    logic [ADDR_W-1:0] o_Mem_Addr;
    logic [DATA_W-1:0] o_Mem_Wdata;
    logic              i_Mem_Ack;
    logic [DATA_W-1:0] i_Mem_Rdata;

    modport master (
        output o_Mem_Req,
        output o_Mem_We,
        output o_Mem_Addr,
        output o_Mem_Wdata,
        input  i_Mem_Ack,
        input  i_Mem_Rdata
    );

    modport slave (
        input  o_Mem_Req,
        input  o_Mem_We,
        input  o_Mem_Addr,
        input  o_Mem_Wdata,
        output i_Mem_Ack,
        output i_Mem_Rdata
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - saturating wait counter for the request phase
// Purpose: counts cycles spent waiting for acknowledge; flags the last
//   allowed cycle and stops there instead of wrapping.
// Ports:
//   i_Clk     clock, rising edge
//   i_Rst_n   asynchronous active-low reset
//   i_Clear   synchronous clear (priority over enable)
//   i_Enable  count one more waiting cycle
//   o_Limit   counter is on the last allowed cycle (LIMIT-1)
module bus_timeout_counter #(
    parameter int LIMIT = 15,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Limit
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_Count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Count <= '0;
        end else if (i_Clear) begin
            r_Count <= '0;
        end else if (i_Enable && !o_Limit) begin
            r_Count <= r_Count + 1'b1;
        end
    end

    assign o_Limit = (r_Count == LAST);

endmodule

// File: rtl/bus_access_sequencer.sv
// rtl/bus_access_sequencer.sv - one-shot memory/IO transaction sequencer
// Purpose: accepts one transaction per start strobe, runs a 4-phase req/ack
//   handshake with memory and reports done/timeout plus read data.
// Ports:
//   i_Clk, i_Rst_n   clock and asynchronous active-low reset
//   i_Start          transaction strobe (ignored while o_Busy)
//   i_Dataout        write data
//   i_Addressdata    address
//   i_ReadWrite      1 = write, 0 = read
//   o_Busy           transaction in flight
//   o_Done           1-cycle completion pulse
//   o_Timeout        1-cycle pulse with o_Done when memory never acknowledged
//   o_Rdata          last successful read data
//   if_Mem           memory handshake bus (master side)
module bus_access_sequencer
    import micro_uaz_defs::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Start,
    input  logic [DATA_W-1:0]     i_Dataout,
    input  logic [ADDR_W-1:0]     i_Addressdata,
    input  logic                  i_ReadWrite,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Timeout,
    output logic [DATA_W-1:0]     o_Rdata,
    bus_access_sequencer_if.master if_Mem
);

    bas_state_t r_State;
    bas_state_t w_State_Next;
    logic       r_Timeout_Flag;

    logic w_Limit;
    logic w_Accept;
    logic w_Ack_Hit;
    logic w_Expire;
    logic w_Finish;
    logic w_Cnt_Clear;
    logic w_Cnt_Enable;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT),
        .CNT_W ($clog2(TIMEOUT + 1))
    ) u_timeout_counter (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Clear  (w_Cnt_Clear),
        .i_Enable (w_Cnt_Enable),
        .o_Limit  (w_Limit)
    );

    // Only REQ accumulates wait cycles; every other state leaves it at zero.
    assign w_Cnt_Clear  = (r_State != ST_REQ);
    assign w_Cnt_Enable = (r_State == ST_REQ) && !if_Mem.i_Mem_Ack;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State <= ST_IDLE;
        end else begin
            r_State <= w_State_Next;
        end
    end

    always_comb begin
        w_State_Next = r_State;
        w_Accept     = 1'b0;
        w_Ack_Hit    = 1'b0;
        w_Expire     = 1'b0;
        w_Finish     = 1'b0;
        case (r_State)
            ST_IDLE: begin
                if (i_Start) begin
                    w_Accept     = 1'b1;
                    w_State_Next = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack is tested first so an ack on the limit cycle still succeeds.
                if (if_Mem.i_Mem_Ack) begin
                    w_Ack_Hit    = 1'b1;
                    w_State_Next = ST_HOLD;
                end else if (w_Limit) begin
                    w_Expire     = 1'b1;
                    w_State_Next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Also swallows an ack that turns up after a timeout.
                if (!if_Mem.i_Mem_Ack) begin
                    w_Finish     = 1'b1;
                    w_State_Next = ST_IDLE;
                end
            end
            default: begin
                w_State_Next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            if_Mem.o_Mem_Req   <= 1'b0;
            if_Mem.o_Mem_We    <= 1'b0;
            if_Mem.o_Mem_Addr  <= '0;
            if_Mem.o_Mem_Wdata <= '0;
            o_Busy             <= 1'b0;
            o_Done             <= 1'b0;
            o_Timeout          <= 1'b0;
            o_Rdata            <= '0;
            r_Timeout_Flag     <= 1'b0;
        end else begin
            if_Mem.o_Mem_Req <= (w_State_Next == ST_REQ);
            o_Busy           <= (w_State_Next != ST_IDLE);
            o_Done           <= w_Finish;
            o_Timeout        <= w_Finish && r_Timeout_Flag;
            if (w_Accept) begin
                if_Mem.o_Mem_Addr  <= i_Addressdata;
                if_Mem.o_Mem_Wdata <= i_Dataout;
                if_Mem.o_Mem_We    <= i_ReadWrite;
                r_Timeout_Flag     <= 1'b0;
            end
            if (w_Expire) begin
                r_Timeout_Flag <= 1'b1;
            end
            if (w_Ack_Hit && (if_Mem.o_Mem_We == RW_READ)) begin
                o_Rdata <= if_Mem.i_Mem_Rdata;
            end
        end
    end

endmodule
